transposer_row_feeder: RTL and testbench
========================================

// Module: transposer_row_feeder
// PURPOSE
//  Upstream stage of the 16x16 transposer: turns one block command plus a stream of scratchpad row reads into
//  exactly DIM rows per block on the transposer's inRow input. Columns >= cols are zeroed. After the
//  row-th input row, all-zero padding rows are inserted. A last flag marks row DIM-1 of each block.
// PARAMETERS
//  DIM  16  rows per block and elements per row
//  W    8   element width in bits
//  CW   $clog2(DIM+1)  width of rows/cols fields (derived localparam, not overridable)
// PORTS
//  clock            in   1       rising-edge clock
//  reset            in   1       asynchronous, active-high reset
//  io_cmd_valid     in   1       block command valid
//  io_cmd_ready     out  1       feeder idle, command accepted on valid&ready
//  io_cmd_rows      in   CW      valid input rows in block (0..DIM)
//  io_cmd_cols      in   CW      valid columns per row (0..DIM)
//  io_rdRow_valid   in   1       scratchpad read row valid
//  io_rdRow_ready   out  1       feeder accepts read row
//  io_rdRow_bits    in   DIM*W   row, element i at [i*W +: W]
//  io_outRow_valid  out  1       row to transposer valid
//  io_outRow_ready  in   1       transposer ready
//  io_outRow_bits   out  DIM*W   masked/padded row, same packing
//  io_outRow_last   out  1       high on the DIM-1'th row of the block
//  io_busy          out  1       state != IDLE
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, cnt=0, rows_q=cols_q=0. Outputs during and after reset:
//   cmd_ready=1, rdRow_ready=0, outRow_valid=0, outRow_bits=0, outRow_last=0, busy=0.
//  Command latch: rows_q=min(rows,DIM), cols_q=min(cols,DIM).
//  Mask: element i is passed when i<cols_q, otherwise 0.
//  FSM IDLE -> cmd fire: latch, cnt=0; next = (rows_q==0) ? PAD : FEED.
//  FEED: out_valid=rdRow_valid, rdRow_ready=out_ready, out_bits=mask(rdRow_bits).
//   On a transfer, cnt++. If cnt==rows_q-1 on that transfer: next = (rows_q==DIM) ? IDLE : PAD.
//  PAD: out_valid=1, out_bits=0, rdRow_ready=0. On each transfer cnt++.
//   On the transfer with cnt==DIM-1, go to IDLE.
//  out_last = out_valid & (cnt==DIM-1). Exactly DIM output transfers per command, never more or fewer.
//  cmd_ready=1 only in IDLE. rdRow_ready=0 outside FEED. Rows arriving in IDLE/PAD stall (not dropped).
//  Latency (no skid): combinational rdRow->outRow in FEED (0 cycles). Back-to-back command allowed
//   the cycle after IDLE re-entry. Throughput: 1 row/cycle.
//  Stall: with out_ready=0, state/cnt hold and bits stay stable while valid is high.
//  Reset mid-block: block is abandoned and no further rows are emitted; the unconsumed reads remain upstream.
// CONFIGURATION
//  TRANSPOSER_FEEDER_SKID_EN defined: output goes through a 2-entry skid buffer, so there is 1-cycle
//   latency, full throughput, and io_rdRow_ready/pad advance no longer depend combinationally on io_outRow_ready.
//   The FSM advances on enqueue into the skid, not on out fire. cmd_ready=1 only when IDLE and the skid is empty.
//   Skid entries reset to invalid.
//  Not defined: the combinational path described above is used, with no extra state.
// STRUCTURE
//  Package transposer_pkg: DIM, W, CW localparams; typedef logic [W-1:0] elem_t; typedef elem_t [DIM-1:0] row_t;
//   typedef enum logic [1:0] {IDLE, FEED, PAD} feeder_state_e; function mask_row(row_t, cols).
//  Sub-module feeder_skid_buf (payload row_t + last bit, valid/ready both sides), instantiated only under the macro.
// TESTING
//  1 rows=16,cols=16, 16 rows with elem=row*16+col, ready=1 -> 16 identical outputs, last on #15, IDLE on the next cycle.
//  2 rows=5,cols=3 -> outputs 0..4 are cols 0..2 kept and 3..15 zero, outputs 5..15 all zero; rdRow_ready=0
//    after the 5th row; exactly 16 transfers.
//  3 rows=0,cols=7 -> 16 zero rows, no rdRow handshake; rows=20,cols=20 -> behaves as 16/16.
//  4 random out_ready/rdRow_valid toggling -> bits stable under stall, no row lost or duplicated, 16 transfers per command.
//  5 two commands back to back -> second cmd_ready rises the cycle after the first block's last; no interleaving.
//  6 reset asserted after output row 7 -> outputs reach reset values asynchronously; a new 16/16 command afterwards
//    streams cleanly from cnt 0 (rerun 1-6 with TRANSPOSER_FEEDER_SKID_EN, expecting +1 cycle latency).

Source files
------------

// File: rtl/transposer_pkg.sv
// Shared types and constants for the transposer row feeder.
// Element and row types, FSM state encoding, column mask and command clamp helpers.
// Optional output skid stage is selected with TRANSPOSER_FEEDER_SKID_EN (see transposer_row_feeder).
package transposer_pkg;

    localparam int DIM = 16;
    localparam int W   = 8;
    localparam int CW  = $clog2(DIM + 1);

    typedef logic [W-1:0]    elem_t;
    typedef elem_t [DIM-1:0] row_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FEED = 2'd1,
        PAD  = 2'd2
    } feeder_state_e;

    // Keep elements below the column count, zero the rest.
    function automatic row_t mask_row(input row_t r, input logic [CW-1:0] cols);
        row_t m;
        for (int i = 0; i < DIM; i++) begin
            m[i] = (i < int'(cols)) ? r[i] : '0;
        end
        return m;
    endfunction

    // Commands may ask for more than DIM rows/cols; anything above DIM behaves as DIM.
    function automatic logic [CW-1:0] clamp_dim(input logic [CW-1:0] v);
        return (v > CW'(DIM)) ? CW'(DIM) : v;
    endfunction

endpackage

// File: rtl/feeder_skid_buf.sv
// Purpose: 2-entry buffer between the feeder FSM and the transposer (row payload + last flag).
// Latency: 1 cycle from enqueue to output valid; sustains 1 row/cycle.
// Backpressure: in_rdy_o comes only from the registered occupancy, never from out_rdy_i.
module feeder_skid_buf
    import transposer_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic in_vld_i,
    output logic in_rdy_o,
    input  row_t in_row_i,
    input  logic in_last_i,
    output logic out_vld_o,
    input  logic out_rdy_i,
    output row_t out_row_o,
    output logic out_last_o,
    output logic empty_o
);

    row_t       data_q [2];
    logic       last_q [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       in_fire, out_fire;

    assign in_rdy_o  = (count_q != 2'd2);
    assign out_vld_o = (count_q != 2'd0);
    assign empty_o   = (count_q == 2'd0);
    assign in_fire   = in_vld_i & in_rdy_o;
    assign out_fire  = out_vld_o & out_rdy_i;

    // Output is forced to zero while no entry is held, so reset presents an all-zero row.
    assign out_row_o  = out_vld_o ? data_q[rd_ptr_q] : '0;
    assign out_last_o = out_vld_o & last_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping.
    always_comb begin
        wr_ptr_d = wr_ptr_q ^ in_fire;
        rd_ptr_d = rd_ptr_q ^ out_fire;
        count_d  = count_q + {1'b0, in_fire} - {1'b0, out_fire};
    end

    // Entry storage and control registers; entries come out of reset invalid and zeroed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                last_q[i] <= 1'b0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (in_fire) begin
                data_q[wr_ptr_q] <= in_row_i;
                last_q[wr_ptr_q] <= in_last_i;
            end
        end
    end

endmodule

// File: rtl/transposer_row_feeder.sv
// Purpose: turns one block command plus scratchpad row reads into exactly DIM masked/padded rows.
// Latency: 0 cycles rdRow->outRow (combinational); 1 cycle with TRANSPOSER_FEEDER_SKID_EN.
// Backpressure: outRow_ready stalls the FSM; with TRANSPOSER_FEEDER_SKID_EN it is absorbed by a 2-entry skid.
module transposer_row_feeder
    import transposer_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              io_cmd_valid,
    output logic              io_cmd_ready,
    input  logic [CW-1:0]     io_cmd_rows,
    input  logic [CW-1:0]     io_cmd_cols,
    input  logic              io_rdRow_valid,
    output logic              io_rdRow_ready,
    input  logic [DIM*W-1:0]  io_rdRow_bits,
    output logic              io_outRow_valid,
    input  logic              io_outRow_ready,
    output logic [DIM*W-1:0]  io_outRow_bits,
    output logic              io_outRow_last,
    output logic              io_busy
);

    feeder_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] rows_q, rows_d;
    logic [CW-1:0] cols_q, cols_d;
    logic [CW-1:0] cmd_rows_clamped;
    logic          cmd_fire;
    logic          enq_vld, enq_rdy, enq_fire, enq_last;
    row_t          enq_row;

    assign cmd_rows_clamped = clamp_dim(io_cmd_rows);
    assign cmd_fire         = io_cmd_valid & io_cmd_ready;
    assign enq_fire         = enq_vld & enq_rdy;
    assign enq_last         = enq_vld & (cnt_q == CW'(DIM - 1));
    assign io_busy          = (state_q != IDLE);

    // Next-state and row-source selection; the FSM counts rows handed downstream.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        rows_d         = rows_q;
        cols_d         = cols_q;
        enq_vld        = 1'b0;
        enq_row        = '0;
        io_rdRow_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    rows_d  = cmd_rows_clamped;
                    cols_d  = clamp_dim(io_cmd_cols);
                    cnt_d   = '0;
                    state_d = (cmd_rows_clamped == '0) ? PAD : FEED;
                end
            end
            FEED: begin
                enq_vld        = io_rdRow_valid;
                io_rdRow_ready = enq_rdy;
                enq_row        = mask_row(row_t'(io_rdRow_bits), cols_q);
                if (enq_fire) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == rows_q - CW'(1)) begin
                        state_d = (rows_q == CW'(DIM)) ? IDLE : PAD;
                    end
                end
            end
            PAD: begin
                enq_vld = 1'b1;
                if (enq_fire) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(DIM - 1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, row counter and latched command fields.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rows_q  <= '0;
            cols_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rows_q  <= rows_d;
            cols_q  <= cols_d;
        end
    end

`ifdef TRANSPOSER_FEEDER_SKID_EN
    logic skid_empty;
    row_t skid_row;

    // Rows are registered before the transposer; the FSM advances on enqueue.
    feeder_skid_buf u_skid (
        .clock      (clock),
        .reset      (reset),
        .in_vld_i   (enq_vld),
        .in_rdy_o   (enq_rdy),
        .in_row_i   (enq_row),
        .in_last_i  (enq_last),
        .out_vld_o  (io_outRow_valid),
        .out_rdy_i  (io_outRow_ready),
        .out_row_o  (skid_row),
        .out_last_o (io_outRow_last),
        .empty_o    (skid_empty)
    );

    assign io_outRow_bits = skid_row;
    // A new block may only start once every row of the previous one has left the skid.
    assign io_cmd_ready   = (state_q == IDLE) & skid_empty;
`else
    // Direct path: the transposer handshake drives the FSM in the same cycle.
    assign enq_rdy         = io_outRow_ready;
    assign io_outRow_valid = enq_vld;
    assign io_outRow_bits  = enq_row;
    assign io_outRow_last  = enq_last;
    assign io_cmd_ready    = (state_q == IDLE);
`endif

endmodule

// File: tb/tb_transposer_row_feeder.sv
// Directed bench for transposer_row_feeder: full, partial, empty and oversize blocks,
// random handshake toggling, back-to-back commands and reset mid-block.
module tb_transposer_row_feeder;
    import transposer_pkg::*;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             io_cmd_valid;
    logic             io_cmd_ready;
    logic [CW-1:0]    io_cmd_rows;
    logic [CW-1:0]    io_cmd_cols;
    logic             io_rdRow_valid;
    logic             io_rdRow_ready;
    logic [DIM*W-1:0] io_rdRow_bits;
    logic             io_outRow_valid;
    logic             io_outRow_ready;
    logic [DIM*W-1:0] io_outRow_bits;
    logic             io_outRow_last;
    logic             io_busy;

    int checks = 0;
    int errors = 0;

    transposer_row_feeder dut (
        .clock           (clock),
        .reset           (reset),
        .io_cmd_valid    (io_cmd_valid),
        .io_cmd_ready    (io_cmd_ready),
        .io_cmd_rows     (io_cmd_rows),
        .io_cmd_cols     (io_cmd_cols),
        .io_rdRow_valid  (io_rdRow_valid),
        .io_rdRow_ready  (io_rdRow_ready),
        .io_rdRow_bits   (io_rdRow_bits),
        .io_outRow_valid (io_outRow_valid),
        .io_outRow_ready (io_outRow_ready),
        .io_outRow_bits  (io_outRow_bits),
        .io_outRow_last  (io_outRow_last),
        .io_busy         (io_busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Upstream row r: element c holds r*16+c.
    function automatic logic [DIM*W-1:0] src_row(input int r);
        logic [DIM*W-1:0] x;
        for (int c = 0; c < DIM; c++) x[c*W +: W] = 8'((r * 16 + c) & 255);
        return x;
    endfunction

    // Expected k-th output row for a block with er rows and ec columns.
    function automatic logic [DIM*W-1:0] exp_row(input int k, input int er, input int ec);
        logic [DIM*W-1:0] x;
        x = '0;
        if (k < er) begin
            x = src_row(k);
            for (int c = ec; c < DIM; c++) x[c*W +: W] = 8'h00;
        end
        return x;
    endfunction

    task automatic reset_checks(input string tag);
        chk({tag, "_cmd_ready"}, io_cmd_ready, 1);
        chk({tag, "_rd_ready"},  io_rdRow_ready, 0);
        chk({tag, "_out_valid"}, io_outRow_valid, 0);
        chk({tag, "_out_bits"},  io_outRow_bits, 0);
        chk({tag, "_out_last"},  io_outRow_last, 0);
        chk({tag, "_busy"},      io_busy, 0);
    endtask

    // Issue one command and stream the block; stop_after>=0 returns after that many output rows.
    task automatic run_block(input int rows, input int cols, input bit rnd, input int stop_after);
        int er, ec, fires, rd, cyc;
        bit pend, stall, rd_fire, out_fire;
        logic [DIM*W-1:0] prev;
        er = (rows > DIM) ? DIM : rows;
        ec = (cols > DIM) ? DIM : cols;
        fires = 0; rd = 0; cyc = 0; pend = 0; stall = 0; prev = '0;
        io_cmd_rows  = CW'(rows);
        io_cmd_cols  = CW'(cols);
        io_cmd_valid = 1'b1;
        #1;
        chk("cmd_ready_at_issue", io_cmd_ready, 1);
        @(posedge clock); #1;
        io_cmd_valid = 1'b0;
        while (fires < DIM) begin
            if (stop_after >= 0 && fires == stop_after) return;
            if (cyc > 600) begin
                chk("block_timeout_rows", fires, DIM);
                break;
            end
            cyc++;
            io_rdRow_valid  = (rd < er) && (pend || !rnd || $urandom_range(1, 0) == 1);
            io_rdRow_bits   = src_row(rd);
            io_outRow_ready = !rnd || $urandom_range(1, 0) == 1;
            #1;
            chk("cmd_ready_while_busy", io_cmd_ready, 0);
            if (stall && io_outRow_valid) chk("stall_bits_stable", io_outRow_bits, prev);
            if (io_outRow_valid) begin
                chk($sformatf("row%0d_bits", fires), io_outRow_bits, exp_row(fires, er, ec));
                chk($sformatf("row%0d_last", fires), io_outRow_last, (fires == DIM - 1));
            end
            rd_fire  = io_rdRow_valid && io_rdRow_ready;
            out_fire = io_outRow_valid && io_outRow_ready;
`ifndef TRANSPOSER_FEEDER_SKID_EN
            chk("rd_ready_follows_out", io_rdRow_ready, (fires < er) ? io_outRow_ready : 1'b0);
            chk("rd_out_lockstep", rd_fire, out_fire && (fires < er));
`endif
            pend  = io_rdRow_valid && !rd_fire;
            stall = io_outRow_valid && !io_outRow_ready;
            prev  = io_outRow_bits;
            if (rd_fire) rd++;
            if (out_fire) fires++;
            @(posedge clock); #1;
        end
        io_rdRow_valid  = 1'b0;
        io_outRow_ready = 1'b1;
        #1;
        chk("idle_after_last_busy", io_busy, 0);
        chk("idle_after_last_cmd_ready", io_cmd_ready, 1);
        chk("no_extra_out_valid", io_outRow_valid, 0);
        chk("reads_consumed", rd, er);
    endtask

    initial begin
        io_cmd_valid    = 1'b0;
        io_cmd_rows     = '0;
        io_cmd_cols     = '0;
        io_rdRow_valid  = 1'b0;
        io_rdRow_bits   = '0;
        io_outRow_ready = 1'b1;
        #2;
        reset_checks("por");
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
        #1;
        reset_checks("post_reset");

        // Full block, partial block, empty block, oversize command.
        run_block(16, 16, 1'b0, -1);
        run_block(5, 3, 1'b0, -1);
        run_block(0, 7, 1'b0, -1);
        run_block(20, 20, 1'b0, -1);

        // Random handshake toggling on both sides.
        run_block(16, 16, 1'b1, -1);
        run_block(5, 3, 1'b1, -1);
        run_block(9, 12, 1'b1, -1);
        run_block(0, 7, 1'b1, -1);

        // Back-to-back commands: the second is issued in the first idle cycle.
        run_block(16, 16, 1'b0, -1);
        run_block(7, 16, 1'b0, -1);

        // Reset after output row 7 with a read still offered.
        run_block(16, 16, 1'b0, 8);
        io_rdRow_valid  = 1'b1;
        io_rdRow_bits   = src_row(8);
        io_outRow_ready = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        reset_checks("mid_block_reset");
        @(posedge clock); #1;
        reset_checks("mid_block_reset_held");
        reset = 1'b0;
        io_rdRow_valid = 1'b0;
        run_block(16, 16, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
